keypad_scan_ctrl: RTL and testbench
===================================

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 Parameter SCAN_CYCLES, default 4800, clock cycles each column is driven before advancing (min 2).
REQ-002 Parameter DEBOUNCE_CYCLES, default 20000, consecutive stable cycles required to accept a press or a release (min 1).
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rows  input  4  keypad row lines, active-low, asynchronous to clk.
REQ-006 cols  output  4  keypad column drive, active-low, exactly one bit low at all times.
REQ-007 new_hex  output  1  high while an accepted key is held; feeds the digit storage FSM.
REQ-008 hex  output  4  code of the last accepted key; valid whenever new_hex=1, otherwise holds the last value.

Function
REQ-009 rows SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rows_s (2-cycle input latency).
REQ-010 Column index col (0..3) SHALL drive cols = ~(4'b0001 << col).
REQ-011 FSM states SHALL be SCAN, PRESS_DB, HELD, RELEASE_DB.
REQ-012 SCAN: dwell counter counts 0..SCAN_CYCLES-1 on the current column; rows_s is sampled only on the last dwell cycle.
REQ-013 SCAN, last dwell cycle, exactly one rows_s bit low: latch col and row, clear counter, go to PRESS_DB; col does not advance.
REQ-014 SCAN, last dwell cycle, zero or more than one rows_s bit low: col advances (3 wraps to 0), counter clears, stay in SCAN.
REQ-015 PRESS_DB: column held; the counter increments each cycle rows_s equals the latched pattern; any mismatch returns to SCAN with col advanced and counter cleared.
REQ-016 PRESS_DB: on the cycle the counter reaches DEBOUNCE_CYCLES-1 with the pattern still matching, go to HELD, register hex per REQ-019, assert new_hex from the next cycle.
REQ-017 HELD: column held; new_hex=1; other keys (other rows in held column, other columns) ignored; when latched row bit of rows_s goes high, clear counter, go to RELEASE_DB.
REQ-018 RELEASE_DB: new_hex stays 1; latched row low again returns to HELD (no new event, hex unchanged); latched row high for DEBOUNCE_CYCLES consecutive cycles goes to SCAN with new_hex=0, col advanced, counter cleared.
REQ-019 Key map (row r, col c) -> hex: r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: E,0,F,D (c0..c3).
REQ-020 new_hex SHALL be a registered output; each accepted press yields exactly one contiguous new_hex high interval, with at least one low cycle between presses.
REQ-021 Counters SHALL be sized to hold max(SCAN_CYCLES, DEBOUNCE_CYCLES)-1 with no overflow; the counter never wraps within a state.
REQ-022 Illegal state encodings SHALL recover to SCAN with new_hex=0.

Reset
REQ-023 While reset=1: state=SCAN, col=0, cols=4'b1110, counters=0, synchronizer flops=4'b1111, latched row/col=0, hex=4'h0, new_hex=0.
REQ-024 Reset asserted mid-press or mid-hold SHALL immediately drop new_hex and restart scanning at col 0 after release.

Verification (SCAN_CYCLES=4, DEBOUNCE_CYCLES=3)
REQ-025 Reset release, no key -> cols cycles 1110,1101,1011,0111,1110 every 4 clocks; new_hex stays 0.
REQ-026 Key r1/c2 held steady -> new_hex rises 3 debounce cycles after detection, hex=4'h6, cols frozen at 1011 while held.
REQ-027 Key r0/c0 bounces (low 1 cycle, high 1 cycle) during PRESS_DB -> no new_hex pulse; scanning resumes at col 1.
REQ-028 Held r3/c1 released with a 1-cycle high glitch then low again -> new_hex stays 1, hex=4'h0 unchanged; final 3-cycle release -> new_hex falls, scan resumes at col 2.
REQ-029 Two rows low on column 3 at sample time -> ignored, col wraps to 0; second key pressed in another column during HELD -> no change to hex or new_hex.
REQ-030 Reset asserted while in HELD with hex=4'hB -> new_hex=0, hex=4'h0, cols=1110 same cycle.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 keypad column scanner with press/release debounce
// One column is driven low at a time; a single accepted key yields one new_hex interval.
module keypad_scan_ctrl #(
    parameter int SCAN_CYCLES     = 4800,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic       new_hex,
    output logic [3:0] hex
);

    localparam int MAX_CYCLES = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    sync1_q, rows_s_q;
    logic [1:0]    col_q, col_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    lrow_q, lrow_d;
    logic [1:0]    lcol_q, lcol_d;
    logic [3:0]    hex_q, hex_d;
    logic          new_hex_q, new_hex_d;

    logic [3:0]    low_n;
    logic          one_low;
    logic [1:0]    low_idx;
    logic          pat_match;

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= 4'hF;
            rows_s_q  <= 4'hF;
            state_q   <= SCAN;
            col_q     <= 2'd0;
            cnt_q     <= '0;
            lrow_q    <= 2'd0;
            lcol_q    <= 2'd0;
            hex_q     <= 4'h0;
            new_hex_q <= 1'b0;
        end else begin
            sync1_q   <= rows;
            rows_s_q  <= sync1_q;
            state_q   <= state_d;
            col_q     <= col_d;
            cnt_q     <= cnt_d;
            lrow_q    <= lrow_d;
            lcol_q    <= lcol_d;
            hex_q     <= hex_d;
            new_hex_q <= new_hex_d;
        end
    end

    // A key is only latched when exactly one row reads low on the sample cycle.
    always_comb begin
        low_n   = ~rows_s_q;
        one_low = (low_n != 4'h0) && ((low_n & (low_n - 4'd1)) == 4'h0);
        low_idx = 2'd0;
        case (low_n)
            4'b0010: low_idx = 2'd1;
            4'b0100: low_idx = 2'd2;
            4'b1000: low_idx = 2'd3;
            default: low_idx = 2'd0;
        endcase
        pat_match = (rows_s_q == ~(4'b0001 << lrow_q));
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        cnt_d     = cnt_q;
        lrow_d    = lrow_q;
        lcol_d    = lcol_q;
        hex_d     = hex_q;
        new_hex_d = new_hex_q;
        case (state_q)
            SCAN: begin
                new_hex_d = 1'b0;
                if (cnt_q == SCAN_LAST) begin
                    cnt_d = '0;
                    if (one_low) begin
                        lrow_d  = low_idx;
                        lcol_d  = col_q;
                        state_d = PRESS_DB;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRESS_DB: begin
                if (!pat_match) begin
                    state_d = SCAN;
                    col_d   = col_q + 2'd1;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = HELD;
                    cnt_d     = '0;
                    hex_d     = key_code(lrow_q, lcol_q);
                    new_hex_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HELD: begin
                new_hex_d = 1'b1;
                if (rows_s_q[lrow_q]) begin
                    cnt_d   = '0;
                    state_d = RELEASE_DB;
                end
            end
            RELEASE_DB: begin
                if (!rows_s_q[lrow_q]) begin
                    state_d = HELD;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = SCAN;
                    new_hex_d = 1'b0;
                    col_d     = col_q + 2'd1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d   = SCAN;
                new_hex_d = 1'b0;
                cnt_d     = '0;
            end
        endcase
    end

    assign cols    = ~(4'b0001 << col_q);
    assign new_hex = new_hex_q;
    assign hex     = hex_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - self-checking bench for keypad_scan_ctrl
// A matrix keypad model drives rows from cols; expected timing comes from scan/debounce arithmetic.
module tb_keypad_scan_ctrl;

    localparam int S = 4;
    localparam int D = 3;
    localparam int SYNC = 2;
    localparam logic [3:0] KEYMAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] rows;
    logic [3:0] cols;
    logic       new_hex;
    logic [3:0] hex;
    logic [15:0] pressed = 16'h0;

    int checks = 0;
    int failures = 0;

    keypad_scan_ctrl #(.SCAN_CYCLES(S), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .rows(rows), .cols(cols), .new_hex(new_hex), .hex(hex)
    );

    always #5 clk = ~clk;

    // Passive keypad: a pressed key shorts its row to its column when that column is driven low.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    function automatic logic [3:0] col_drive(int c);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << c);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_key(int r, int c, logic v);
        pressed[r*4+c] = v;
    endtask

    task automatic wait_col(int c, input logic leave_first, output logic ok);
        int n;
        ok = 1'b1;
        n = 0;
        if (leave_first) begin
            while (cols == col_drive(c) && n < 40) begin tick(); n++; end
        end
        n = 0;
        while (cols != col_drive(c) && n < 40) begin tick(); n++; end
        checks++;
        if (cols != col_drive(c)) begin
            failures++;
            ok = 1'b0;
            $display("FAIL wait_col%0d: cols=%b never reached %b", c, cols, col_drive(c));
        end
    endtask

    task automatic press_and_check(int r, int c, string tag);
        logic ok;
        wait_col(c, 1'b1, ok);
        if (!ok) return;
        wait_col((c + 3) % 4, 1'b0, ok);
        if (!ok) return;
        set_key(r, c, 1'b1);
        wait_col(c, 1'b0, ok);
        if (!ok) return;
        for (int k = 1; k < S + D; k++) begin
            tick();
            checks++;
            if (new_hex !== 1'b0 || cols !== col_drive(c)) begin
                failures++;
                $display("FAIL %s_debounce k=%0d: new_hex=%b cols=%b expected 0/%b", tag, k, new_hex, cols, col_drive(c));
            end
        end
        tick();
        checks++;
        if (new_hex !== 1'b1 || hex !== KEYMAP[r*4+c] || cols !== col_drive(c)) begin
            failures++;
            $display("FAIL %s_accept: new_hex=%b hex=%h cols=%b expected 1/%h/%b", tag, new_hex, hex, cols, KEYMAP[r*4+c], col_drive(c));
        end
    endtask

    task automatic hold_check(int n, int r, int c, string tag);
        for (int k = 0; k < n; k++) begin
            tick();
            checks++;
            if (new_hex !== 1'b1 || hex !== KEYMAP[r*4+c] || cols !== col_drive(c)) begin
                failures++;
                $display("FAIL %s_hold k=%0d: new_hex=%b hex=%h cols=%b expected 1/%h/%b", tag, k, new_hex, hex, cols, KEYMAP[r*4+c], col_drive(c));
            end
        end
    endtask

    task automatic release_and_check(int r, int c, string tag);
        set_key(r, c, 1'b0);
        hold_check(SYNC + D, r, c, {tag, "_rel"});
        tick();
        checks++;
        if (new_hex !== 1'b0 || hex !== KEYMAP[r*4+c] || cols !== col_drive((c + 1) % 4)) begin
            failures++;
            $display("FAIL %s_release: new_hex=%b hex=%h cols=%b expected 0/%h/%b", tag, new_hex, hex, cols, KEYMAP[r*4+c], col_drive((c + 1) % 4));
        end
    endtask

    task automatic check_scan_from_reset(int n, string tag);
        for (int k = 1; k <= n; k++) begin
            tick();
            checks++;
            if (cols !== col_drive((k / S) % 4) || new_hex !== 1'b0) begin
                failures++;
                $display("FAIL %s k=%0d: cols=%b new_hex=%b expected %b/0", tag, k, cols, new_hex, col_drive((k / S) % 4));
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if (cols !== 4'b1110 || new_hex !== 1'b0 || hex !== 4'h0) begin
            failures++;
            $display("FAIL reset_state: cols=%b new_hex=%b hex=%h expected 1110/0/0", cols, new_hex, hex);
        end
        repeat (3) tick();
        checks++;
        if (cols !== 4'b1110 || new_hex !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: cols=%b new_hex=%b expected 1110/0", cols, new_hex);
        end
        reset = 1'b0;
    endtask

    task automatic test_idle_scan();
        check_scan_from_reset(5 * S, "idle_scan");
    endtask

    task automatic test_steady_press();
        press_and_check(1, 2, "r1c2");
        hold_check(6, 1, 2, "r1c2");
        release_and_check(1, 2, "r1c2");
    endtask

    task automatic test_bounce();
        logic ok;
        wait_col(0, 1'b1, ok);
        if (!ok) return;
        wait_col(3, 1'b0, ok);
        if (!ok) return;
        set_key(0, 0, 1'b1);
        wait_col(0, 1'b0, ok);
        if (!ok) return;
        repeat (S) tick();
        set_key(0, 0, 1'b0);
        tick();
        set_key(0, 0, 1'b1);
        tick();
        tick();
        checks++;
        if (cols !== 4'b1101 || new_hex !== 1'b0) begin
            failures++;
            $display("FAIL bounce_resume: cols=%b new_hex=%b expected 1101/0", cols, new_hex);
        end
        set_key(0, 0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++;
            if (new_hex !== 1'b0) begin
                failures++;
                $display("FAIL bounce_no_pulse k=%0d: new_hex=%b expected 0", k, new_hex);
            end
        end
    endtask

    task automatic test_release_glitch();
        press_and_check(3, 1, "r3c1");
        set_key(3, 1, 1'b0);
        tick();
        set_key(3, 1, 1'b1);
        hold_check(8, 3, 1, "glitch");
        release_and_check(3, 1, "r3c1");
    endtask

    task automatic test_multi_key();
        logic ok;
        wait_col(3, 1'b1, ok);
        if (!ok) return;
        wait_col(2, 1'b0, ok);
        if (!ok) return;
        set_key(0, 3, 1'b1);
        set_key(2, 3, 1'b1);
        wait_col(3, 1'b0, ok);
        if (!ok) return;
        repeat (S) tick();
        checks++;
        if (cols !== 4'b1110 || new_hex !== 1'b0) begin
            failures++;
            $display("FAIL two_rows_ignored: cols=%b new_hex=%b expected 1110/0", cols, new_hex);
        end
        set_key(0, 3, 1'b0);
        set_key(2, 3, 1'b0);
        press_and_check(2, 0, "r2c0");
        set_key(0, 2, 1'b1);
        set_key(1, 0, 1'b1);
        hold_check(10, 2, 0, "second_key");
        set_key(0, 2, 1'b0);
        set_key(1, 0, 1'b0);
        release_and_check(2, 0, "r2c0");
    endtask

    task automatic test_random_keys();
        int r, c, h;
        for (int i = 0; i < 8; i++) begin
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            h = $urandom_range(0, 15);
            press_and_check(r, c, "rand");
            hold_check(h, r, c, "rand");
            release_and_check(r, c, "rand");
        end
    endtask

    task automatic test_reset_in_held();
        press_and_check(1, 3, "r1c3");
        repeat (2) tick();
        reset = 1'b1;
        #1;
        checks++;
        if (new_hex !== 1'b0 || hex !== 4'h0 || cols !== 4'b1110) begin
            failures++;
            $display("FAIL reset_in_held: new_hex=%b hex=%h cols=%b expected 0/0/1110", new_hex, hex, cols);
        end
        set_key(1, 3, 1'b0);
        repeat (2) tick();
        reset = 1'b0;
        check_scan_from_reset(2 * S, "rescan_after_reset");
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_steady_press();
        test_bounce();
        test_release_glitch();
        test_multi_key();
        test_random_keys();
        test_reset_in_held();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
